pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, memory-wait freeze
// with timeout, and saturating stall/flush statistics.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        ex_branch_taken,
    input  logic        id_jump,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        clr_cnt,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        exmem_write,
    output logic        ifid_flush,
    output logic        idex_null,
    output logic        mem_timeout,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_TIMEOUT  = 2'b10
    } state_t;

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic w_load_use;
    logic w_mem_stall;
    logic w_freeze;

    assign w_load_use  = idex_memread && (idex_rt != 5'd0) &&
                         ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    assign w_mem_stall = mem_req && !mem_ready;
    // Any state other than RUN (including the unused encoding) holds the pipeline.
    assign w_freeze    = (r_state != ST_RUN) || w_mem_stall;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_null   = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            idex_null   = 1'b1;
        end else if (w_freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_null   = 1'b1;
        end else if (w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_null   = 1'b1;
        end else if (id_jump) begin
            ifid_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt == 4'd15) begin
                        r_state <= ST_TIMEOUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                ST_TIMEOUT: r_state <= ST_TIMEOUT;
                default:    r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (ifid_flush && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign state       = r_state;
    assign mem_timeout = (r_state == ST_TIMEOUT);
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
